// File: rtl/sm_seq_mul.sv
// Sequential sign-magnitude multiplier: shift-add over one magnitude bit per clock,
// with a start/busy/done handshake, zero bypass and negative-zero normalisation.
module sm_seq_mul #(
    parameter int MAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [MAG_W:0]   i_A,
    input  logic [MAG_W:0]   i_B,
    output logic             o_busy,
    output logic             o_done,
    output logic [2*MAG_W:0] o_res,
    output logic             o_Z
);

    localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
    localparam int ACC_W = 2 * MAG_W;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    logic             sgn;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] partial;
    logic [CNT_W-1:0] cnt;
    logic             op_zero;
    logic             load;
    logic             bypass;
    logic             finish;

    // Either magnitude being zero (including -0) short-circuits the whole iteration.
    assign op_zero  = (i_A[MAG_W-1:0] == '0) || (i_B[MAG_W-1:0] == '0);
    assign partial  = {{MAG_W{1'b0}}, mag_a} << cnt;
    assign acc_next = mag_b[cnt] ? acc + partial : acc;
    assign o_busy   = (state == CALC);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        bypass     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (op_zero) begin
                        bypass = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt == CNT_W'(MAG_W - 1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the operand/accumulator registers are plain flops, not a memory array, so clearing them on reset is cheap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mag_a  <= '0;
            mag_b  <= '0;
            sgn    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            o_done <= 1'b0;
            o_res  <= '0;
            o_Z    <= 1'b1;
        end else begin
            o_done <= bypass | finish;
            if (load || bypass) begin
                mag_a <= i_A[MAG_W-1:0];
                mag_b <= i_B[MAG_W-1:0];
                sgn   <= i_A[MAG_W] ^ i_B[MAG_W];
            end
            if (load) begin
                acc <= '0;
                cnt <= '0;
            end
            if (bypass) begin
                o_res <= '0;
                o_Z   <= 1'b1;
            end
            if (state == CALC) begin
                acc <= acc_next;
                cnt <= cnt + CNT_W'(1);
            end
            // Sign is gated by a non-zero magnitude so -0 can never be produced.
            if (finish) begin
                o_res <= {sgn && (acc_next != '0), acc_next};
                o_Z   <= (acc_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_sm_seq_mul.sv
// Directed and sweep bench for sm_seq_mul at MAG_W=4 and MAG_W=2, using immediate assertions.
module tb_sm_seq_mul;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start2;
    logic [4:0] a4, b4;
    logic [2:0] a2, b2;
    logic       busy4, done4, z4;
    logic       busy2, done2, z2;
    logic [8:0] res4;
    logic [4:0] res2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm_seq_mul #(.MAG_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_A(a4), .i_B(b4),
        .o_busy(busy4), .o_done(done4), .o_res(res4), .o_Z(z4)
    );

    sm_seq_mul #(.MAG_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_A(a2), .i_B(b2),
        .o_busy(busy2), .o_done(done2), .o_res(res2), .o_Z(z2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits for done on the MAG_W=4 instance; k counts edges after the current point.
    task automatic wait_done4(output int k);
        k = 0;
        while (!done4 && k < 40) begin
            tick();
            k++;
        end
    endtask

    // One full MAG_W=4 transaction; lat = edges after the start edge until done is seen.
    task automatic run4(input logic [4:0] a, input logic [4:0] b, input logic [8:0] exp_res,
                        input logic exp_z, input int exp_lat, input string tag);
        int k;
        a4 = a; b4 = b; start4 = 1'b1;
        tick();
        start4 = 1'b0; a4 = ~a; b4 = ~b;
        k = 0;
        while (!done4 && k < 40) begin
            check({tag, " busy"}, busy4, 1);
            tick();
            k++;
        end
        check({tag, " done"}, done4, 1);
        check({tag, " busy_at_done"}, busy4, 0);
        check({tag, " latency"}, k, exp_lat);
        check({tag, " res"}, res4, exp_res);
        check({tag, " z"}, z4, exp_z);
        tick();
        check({tag, " done_pulse"}, done4, 0);
    endtask

    task automatic run2(input logic [2:0] a, input logic [2:0] b, input logic [4:0] exp_res,
                        input logic exp_z, input int exp_lat, input string tag);
        int k;
        a2 = a; b2 = b; start2 = 1'b1;
        tick();
        start2 = 1'b0; a2 = ~a; b2 = ~b;
        k = 0;
        while (!done2 && k < 40) begin
            check({tag, " busy"}, busy2, 1);
            tick();
            k++;
        end
        check({tag, " done"}, done2, 1);
        check({tag, " latency"}, k, exp_lat);
        check({tag, " res"}, res2, exp_res);
        check({tag, " z"}, z2, exp_z);
        tick();
        check({tag, " done_pulse"}, done2, 0);
    endtask

    initial begin
        int k;
        int ma, mb, p;
        logic sf;
        logic [4:0] ia5, ib5;
        logic [2:0] ia3, ib3;

        rst = 1'b1; start4 = 1'b0; start2 = 1'b0;
        a4 = '0; b4 = '0; a2 = '0; b2 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", busy4, 0);
        check("reset done", done4, 0);
        check("reset res", res4, 9'h000);
        check("reset z", z4, 1);
        check("reset2 z", z2, 1);

        // -3 * +5 = -15
        run4(5'b1_0011, 5'b0_0101, 9'b1_00001111, 1'b0, 4, "neg3_pos5");
        // -0 and zero-magnitude operands take the bypass path
        run4(5'b1_0000, 5'b0_0111, 9'b0_00000000, 1'b1, 0, "negzero_a");
        run4(5'b1_0101, 5'b1_0000, 9'b0_00000000, 1'b1, 0, "negzero_b");
        run4(5'b1_1111, 5'b1_1111, 9'b0_11100001, 1'b0, 4, "max_sq");
        run4(5'b0_1111, 5'b1_0001, 9'b1_00001111, 1'b0, 4, "pos15_neg1");

        // start while busy is ignored; start in the done cycle is accepted
        a4 = 5'b0_0010; b4 = 5'b0_0011; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("ign busy1", busy4, 1);
        tick();
        a4 = 5'b0_1111; b4 = 5'b0_1111; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4(k);
        check("ign latency", k + 2, 4);
        check("ign res", res4, 9'b0_00000110);
        check("ign z", z4, 0);
        a4 = 5'b0_1111; b4 = 5'b0_1111; start4 = 1'b1;
        tick();
        start4 = 1'b0; a4 = '0; b4 = '0;
        check("b2b done_drop", done4, 0);
        check("b2b busy", busy4, 1);
        check("b2b res_held", res4, 9'b0_00000110);
        wait_done4(k);
        check("b2b latency", k, 4);
        check("b2b res", res4, 9'b0_11100001);
        tick();

        // reset mid-CALC aborts with no done
        a4 = 5'b0_1010; b4 = 5'b0_1010; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", busy4, 0);
        check("abort done", done4, 0);
        check("abort res", res4, 9'h000);
        check("abort z", z4, 1);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done4) k++;
        end
        check("abort no_done", k, 0);

        // reset wins over a simultaneous start
        a4 = 5'b0_0011; b4 = 5'b0_0011; start4 = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; start4 = 1'b0;
        check("rst_over_start busy", busy4, 0);
        tick();
        check("rst_over_start done", done4, 0);

        for (int ia = 0; ia < 32; ia++) begin
            for (int ib = 0; ib < 32; ib++) begin
                ia5 = ia[4:0]; ib5 = ib[4:0];
                ma = ia % 16; mb = ib % 16; p = ma * mb;
                sf = (ia5[4] ^ ib5[4]) && (p != 0);
                run4(ia5, ib5, {sf, p[7:0]}, p == 0, (p == 0) ? 0 : 4, "sweep4");
            end
        end

        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                ia3 = ia[2:0]; ib3 = ib[2:0];
                ma = ia % 4; mb = ib % 4; p = ma * mb;
                sf = (ia3[2] ^ ib3[2]) && (p != 0);
                run2(ia3, ib3, {sf, p[3:0]}, p == 0, (p == 0) ? 0 : 2, "sweep2");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
